// File: rtl/pend_grant_server.sv
// pend_grant_server
//
// Sequential request server feeding the 12-input priority encoder path.
// Pulsed requests are captured into a sticky pending register; one grant at a
// time is issued over a valid/ready handshake, highest-numbered pending line
// first. A line is retired on its handshake. A repeat request on a line that
// is already pending is collapsed and flagged as an overrun.
//
// Optional feature macro: PEND_SECOND_EN
//   When defined, out2_idx/out2_hit report the second-highest pending line
//   captured at grant load time (informational only).
//
// Ports:
//   clk        in   single clock, all state on rising edge
//   rst_n      in   synchronous active-low reset
//   req        in   [NREQ-1:0] request pulses, set pending bits
//   out_idx    out  [3:0] granted line index, 4'hF when no grant is loaded
//   out_valid  out  grant presented
//   out_ready  in   consumer accepts grant (ignored while idle)
//   pending    out  [NREQ-1:0] current pending register
//   overrun    out  sticky repeat-request flag
//   ovr_clr    in   clears overrun (a simultaneous set wins)
//   grant_cnt  out  [CNT_W-1:0] completed handshakes, saturating
//   out2_idx   out  [3:0] second-highest pending at load (PEND_SECOND_EN)
//   out2_hit   out  out2_idx is valid (PEND_SECOND_EN)

module pend_grant_server #(
   parameter int unsigned NREQ  = 12,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   output logic [3:0]       out_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NREQ-1:0]  pending,
   output logic             overrun,
   input  logic             ovr_clr,
   output logic [CNT_W-1:0] grant_cnt
`ifdef PEND_SECOND_EN
   ,
   output logic [3:0]       out2_idx,
   output logic             out2_hit
`endif
);

   localparam logic [3:0] IDX_NONE = 4'hF;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   pending_q, pending_d;
   logic [3:0]        out_idx_q, out_idx_d;
   logic              overrun_q, overrun_d;
   logic [CNT_W-1:0]  grant_cnt_q, grant_cnt_d;

   logic              hs;
   logic [NREQ-1:0]   retire_mask;
   logic [3:0]        top_idx;

   // Highest set bit; IDX_NONE when the vector is empty.
   function automatic logic [3:0] highest(input logic [NREQ-1:0] v);
      logic [3:0] idx;
      idx = IDX_NONE;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   assign hs          = (state_q == GRANT) && out_ready;
   assign retire_mask = hs ? (NREQ'(1) << out_idx_q) : '0;
   assign top_idx     = highest(pending_q);

`ifdef PEND_SECOND_EN
   logic [3:0]      out2_idx_q, out2_idx_d;
   logic            out2_hit_q, out2_hit_d;
   logic [NREQ-1:0] rest;

   // Pending with the top line removed; its highest bit is the runner-up.
   assign rest = pending_q & ~(NREQ'(1) << top_idx);
`endif

   always_comb begin
      state_d     = state_q;
      out_idx_d   = out_idx_q;
`ifdef PEND_SECOND_EN
      out2_idx_d  = out2_idx_q;
      out2_hit_d  = out2_hit_q;
`endif
      // A new request overrides a retire on the same edge.
      pending_d   = (pending_q & ~retire_mask) | req;

      if (|(req & pending_q & ~retire_mask)) begin
         overrun_d = 1'b1;
      end else if (ovr_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end

      grant_cnt_d = grant_cnt_q;
      if (hs && (grant_cnt_q != '1)) begin
         grant_cnt_d = grant_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (pending_q != '0) begin
               out_idx_d  = top_idx;
`ifdef PEND_SECOND_EN
               out2_idx_d = highest(rest);
               out2_hit_d = (rest != '0);
`endif
               state_d    = GRANT;
            end else begin
               out_idx_d  = IDX_NONE;
            end
         end
         GRANT: begin
            if (out_ready) begin
               out_idx_d  = IDX_NONE;
`ifdef PEND_SECOND_EN
               out2_idx_d = IDX_NONE;
               out2_hit_d = 1'b0;
`endif
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         out_idx_q   <= IDX_NONE;
         overrun_q   <= 1'b0;
         grant_cnt_q <= '0;
`ifdef PEND_SECOND_EN
         out2_idx_q  <= IDX_NONE;
         out2_hit_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         out_idx_q   <= out_idx_d;
         overrun_q   <= overrun_d;
         grant_cnt_q <= grant_cnt_d;
`ifdef PEND_SECOND_EN
         out2_idx_q  <= out2_idx_d;
         out2_hit_q  <= out2_hit_d;
`endif
      end
   end

   assign out_idx   = out_idx_q;
   assign out_valid = (state_q == GRANT);
   assign pending   = pending_q;
   assign overrun   = overrun_q;
   assign grant_cnt = grant_cnt_q;
`ifdef PEND_SECOND_EN
   assign out2_idx  = out2_idx_q;
   assign out2_hit  = out2_hit_q;
`endif

endmodule

// File: tb/tb_pend_grant_server.sv
// Directed bench for pend_grant_server. Inputs change 1 time unit after a
// rising edge; outputs are checked at the same point, away from the edge.

module tb_pend_grant_server;

   logic        clk;
   logic        rst_n;
   logic [11:0] req;
   logic [3:0]  out_idx;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] pending;
   logic        overrun;
   logic        ovr_clr;
   logic [7:0]  grant_cnt;
`ifdef PEND_SECOND_EN
   logic [3:0]  out2_idx;
   logic        out2_hit;
`endif

   int n_assert;
   int n_fail;

   pend_grant_server #(
      .NREQ  (12),
      .CNT_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .out_idx   (out_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pending   (pending),
      .overrun   (overrun),
      .ovr_clr   (ovr_clr),
      .grant_cnt (grant_cnt)
`ifdef PEND_SECOND_EN
      ,
      .out2_idx  (out2_idx),
      .out2_hit  (out2_hit)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req       = '0;
      out_ready = 1'b0;
      ovr_clr   = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      check("rst_pending", 32'(pending), 32'h000);
      check("rst_idx", 32'(out_idx), 32'hF);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_cnt", 32'(grant_cnt), 32'h0);
`ifdef PEND_SECOND_EN
      check("rst_out2_idx", 32'(out2_idx), 32'hF);
      check("rst_out2_hit", 32'(out2_hit), 32'h0);
`endif

      // Single pulse on line 0, two-cycle latency, then handshake
      req = 12'h001;
      tick();
      req = '0;
      check("t1_pend", 32'(pending), 32'h001);
      check("t1_valid_e", 32'(out_valid), 32'h0);
      tick();
      check("t1_valid", 32'(out_valid), 32'h1);
      check("t1_idx", 32'(out_idx), 32'h0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t1_valid_h", 32'(out_valid), 32'h0);
      check("t1_pend_h", 32'(pending), 32'h000);
      check("t1_cnt", 32'(grant_cnt), 32'h1);
      check("t1_idx_h", 32'(out_idx), 32'hF);

      // 12'hA04 with ready held high: 11, 9, 2, one idle cycle between
      out_ready = 1'b1;
      req = 12'hA04;
      tick();
      req = '0;
      check("t2_pend0", 32'(pending), 32'hA04);
      check("t2_v0", 32'(out_valid), 32'h0);
      tick();
      check("t2_v1", 32'(out_valid), 32'h1);
      check("t2_idx11", 32'(out_idx), 32'd11);
      tick();
      check("t2_v1i", 32'(out_valid), 32'h0);
      check("t2_pend1", 32'(pending), 32'h204);
      tick();
      check("t2_v2", 32'(out_valid), 32'h1);
      check("t2_idx9", 32'(out_idx), 32'd9);
      tick();
      check("t2_v2i", 32'(out_valid), 32'h0);
      check("t2_pend2", 32'(pending), 32'h004);
      tick();
      check("t2_v3", 32'(out_valid), 32'h1);
      check("t2_idx2", 32'(out_idx), 32'd2);
      tick();
      check("t2_v3i", 32'(out_valid), 32'h0);
      check("t2_pend3", 32'(pending), 32'h000);
      check("t2_cnt", 32'(grant_cnt), 32'd4);
      out_ready = 1'b0;

      // Stall on line 5 for 10 cycles, line 10 arrives mid-stall
      req = 12'h020;
      tick();
      req = '0;
      tick();
      check("t3_valid", 32'(out_valid), 32'h1);
      check("t3_idx5", 32'(out_idx), 32'd5);
      for (int i = 0; i < 10; i++) begin
         req = (i == 2) ? 12'h400 : 12'h000;
         tick();
         check("t3_hold_idx", 32'(out_idx), 32'd5);
         check("t3_hold_valid", 32'(out_valid), 32'h1);
      end
      req = '0;
      check("t3_pend", 32'(pending), 32'h420);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t3_valid_h", 32'(out_valid), 32'h0);
      check("t3_pend_h", 32'(pending), 32'h400);
      check("t3_cnt", 32'(grant_cnt), 32'd5);
      tick();
      check("t3_next_valid", 32'(out_valid), 32'h1);
      check("t3_idx10", 32'(out_idx), 32'd10);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t3_cnt2", 32'(grant_cnt), 32'd6);
      check("t3_pend2", 32'(pending), 32'h000);

      // Request on line 3 on the same edge it retires
      req = 12'h008;
      tick();
      req = '0;
      tick();
      check("t4_idx3", 32'(out_idx), 32'd3);
      out_ready = 1'b1;
      req = 12'h008;
      tick();
      req = '0;
      out_ready = 1'b0;
      check("t4_pend", 32'(pending), 32'h008);
      check("t4_ovr", 32'(overrun), 32'h0);
      check("t4_cnt", 32'(grant_cnt), 32'd7);
      check("t4_valid_h", 32'(out_valid), 32'h0);
      tick();
      check("t4_regrant_v", 32'(out_valid), 32'h1);
      check("t4_regrant_i", 32'(out_idx), 32'd3);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t4_cnt2", 32'(grant_cnt), 32'd8);
      check("t4_pend2", 32'(pending), 32'h000);

      // Overrun on line 7, clear, set-beats-clear, then reset mid-grant
      req = 12'h080;
      tick();
      req = '0;
      check("t5_ovr0", 32'(overrun), 32'h0);
      tick();
      check("t5_idx7", 32'(out_idx), 32'd7);
      req = 12'h080;
      tick();
      req = '0;
      check("t5_ovr1", 32'(overrun), 32'h1);
      ovr_clr = 1'b1;
      tick();
      check("t5_ovr_clr", 32'(overrun), 32'h0);
      req = 12'h080;
      tick();
      req = '0;
      check("t5_set_wins", 32'(overrun), 32'h1);
      tick();
      ovr_clr = 1'b0;
      check("t5_ovr_clr2", 32'(overrun), 32'h0);
      check("t5_still_valid", 32'(out_valid), 32'h1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t5_rst_valid", 32'(out_valid), 32'h0);
      check("t5_rst_idx", 32'(out_idx), 32'hF);
      check("t5_rst_cnt", 32'(grant_cnt), 32'h0);
      check("t5_rst_pend", 32'(pending), 32'h000);
      check("t5_rst_ovr", 32'(overrun), 32'h0);

`ifdef PEND_SECOND_EN
      // Runner-up reporting for pending 12'h830
      req = 12'h830;
      tick();
      req = '0;
      tick();
      check("t6_idx11", 32'(out_idx), 32'd11);
      check("t6_o2_5", 32'(out2_idx), 32'd5);
      check("t6_hit1", 32'(out2_hit), 32'h1);
      out_ready = 1'b1;
      tick();
      tick();
      check("t6_idx5", 32'(out_idx), 32'd5);
      check("t6_o2_4", 32'(out2_idx), 32'd4);
      check("t6_hit2", 32'(out2_hit), 32'h1);
      tick();
      tick();
      check("t6_idx4", 32'(out_idx), 32'd4);
      check("t6_o2_none", 32'(out2_idx), 32'hF);
      check("t6_hit0", 32'(out2_hit), 32'h0);
      tick();
      out_ready = 1'b0;
      check("t6_cnt", 32'(grant_cnt), 32'd3);
`endif

      // Counter saturation: one grant per two cycles, well over 255 grants
      out_ready = 1'b1;
      req = 12'h001;
      for (int i = 0; i < 600; i++) tick();
      req = '0;
      tick();
      tick();
      tick();
      check("t7_sat", 32'(grant_cnt), 32'hFF);
      check("t7_pend", 32'(pending), 32'h000);
      out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
